// File: rtl/sequence_frame_transmitter_if.sv
// Producer and serial-stream signals of the sequence frame transmitter.
// Optional macro SEQ_TX_EXPECT_EN adds the golden expect_dec flag.
interface sequence_frame_transmitter_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       out_valid;
  logic       frame_first;
`ifdef SEQ_TX_EXPECT_EN
  logic       expect_dec;

  // Producer / stream consumer side
  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_valid, frame_first, expect_dec
  );

  // Transmitter side
  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_valid, frame_first, expect_dec
  );
`else
  // Producer / stream consumer side
  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_valid, frame_first
  );

  // Transmitter side
  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_valid, frame_first
  );
`endif
endinterface

// File: rtl/sequence_frame_transmitter.sv
// Buffers 4-bit frame words in a circular FIFO and serializes them MSB first,
// back to back, as the stimulus stream for a sequence detector.
// Optional macro SEQ_TX_EXPECT_EN compiles in the registered expect_dec flag,
// high during the last bit of frames 1011, 1010 and 0011.
module sequence_frame_transmitter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sequence_frame_transmitter_if.slave  bus
);

  localparam int unsigned WORD_W = 4;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;

  typedef enum logic [2:0] {IDLE, B3, B2, B1, B0} state_t;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic              out_q;
  logic              out_valid_q;
  logic              frame_first_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && ((state == IDLE) || (state == B0));

  // Ready ignores a same-cycle pop and is held low while in reset
  assign bus.in_ready    = rst_n && !full;
  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_first = frame_first_q;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= bus.in_data;
  end

  // FIFO pointers; wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Serializer FSM; outputs register the current state, one cycle behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_first_q <= 1'b0;
    end else begin
      out_q         <= (state != IDLE) && shreg[WORD_W-1];
      out_valid_q   <= (state != IDLE);
      frame_first_q <= (state == B3);
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= B3;
            shreg <= mem[rptr[AW-1:0]];
          end
        end
        B3: begin
          state <= B2;
          shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
        B2: begin
          state <= B1;
          shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
        B1: begin
          state <= B0;
          shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
        B0: begin
          if (pop) begin
            state <= B3;
            shreg <= mem[rptr[AW-1:0]];
          end else begin
            state <= IDLE;
            shreg <= '0;
          end
        end
        default: begin
          state <= IDLE;
          shreg <= '0;
        end
      endcase
    end
  end

`ifdef SEQ_TX_EXPECT_EN
  logic [WORD_W-1:0] word_q;
  logic              expect_dec_q;

  assign bus.expect_dec = expect_dec_q;

  // Golden detect flag aligned with the last serialized bit of a matching word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      expect_dec_q <= 1'b0;
    end else begin
      if (pop) word_q <= mem[rptr[AW-1:0]];
      expect_dec_q <= (state == B0) &&
                      ((word_q == 4'b1011) || (word_q == 4'b1010) ||
                       (word_q == 4'b0011));
    end
  end
`endif

endmodule

// File: tb/tb_sequence_frame_transmitter.sv
// Directed bench for sequence_frame_transmitter; honours SEQ_TX_EXPECT_EN.
module tb_sequence_frame_transmitter;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sequence_frame_transmitter_if bus ();

  sequence_frame_transmitter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stream monitor: records every valid bit, sampled on the falling edge
  logic obs_bits  [$];
  logic obs_first [$];
  logic obs_dec   [$];
  int   obs_cyc   [$];
  int   cyc;
  int   stray;

  initial begin
    cyc   = 0;
    stray = 0;
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      obs_bits.push_back(bus.out);
      obs_first.push_back(bus.frame_first);
      obs_cyc.push_back(cyc);
`ifdef SEQ_TX_EXPECT_EN
      obs_dec.push_back(bus.expect_dec);
`else
      obs_dec.push_back(1'b0);
`endif
    end else begin
`ifdef SEQ_TX_EXPECT_EN
      if (bus.out || bus.frame_first || bus.expect_dec) stray++;
`else
      if (bus.out || bus.frame_first) stray++;
`endif
    end
    cyc++;
  end

  function automatic logic golden_dec(input logic [3:0] w);
    return (w == 4'b1011) || (w == 4'b1010) || (w == 4'b0011);
  endfunction

  task automatic clear_obs();
    obs_bits.delete();
    obs_first.delete();
    obs_dec.delete();
    obs_cyc.delete();
  endtask

  task automatic push_word(input logic [3:0] w);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int idle;
    int n;
    idle = 0;
    n    = 0;
    while (idle < 3 && n < 400) begin
      @(negedge clk);
      if (bus.out_valid) idle = 0;
      else idle++;
      n++;
    end
    if (idle < 3) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout idle=%0d required=3", idle);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out, bus.out_valid, bus.frame_first, bus.in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0000",
               {bus.out, bus.out_valid, bus.frame_first, bus.in_ready});
    end
`ifdef SEQ_TX_EXPECT_EN
    checks++;
    if (bus.expect_dec !== 1'b0) begin
      errors++;
      $display("FAIL reset_expect_dec got=%b required=0", bus.expect_dec);
    end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid got=%b required=0", bus.out_valid);
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    logic [2:0] exp_v;
    w = 4'b1011;
    push_word(w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_latency_%0d out_valid=%b required=0", i, bus.out_valid);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = {1'b1, w[3-i], (i == 0)};
      checks++;
      if ({bus.out_valid, bus.out, bus.frame_first} !== exp_v) begin
        errors++;
        $display("FAIL single_bit_%0d got=%b required=%b", i,
                 {bus.out_valid, bus.out, bus.frame_first}, exp_v);
      end
`ifdef SEQ_TX_EXPECT_EN
      checks++;
      if (bus.expect_dec !== (i == 3)) begin
        errors++;
        $display("FAIL single_dec_%0d got=%b required=%b", i, bus.expect_dec, (i == 3));
      end
`endif
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.frame_first} !== 3'b000) begin
      errors++;
      $display("FAIL single_after got=%b required=000",
               {bus.out_valid, bus.out, bus.frame_first});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_bits;
    logic [1:0]  exp_v;
    logic [1:0]  got_v;
    exp_bits = 12'b1010_0011_0010;
    clear_obs();
    push_word(4'b1010);
    push_word(4'b0011);
    push_word(4'b0010);
    drain();
    checks++;
    if (obs_bits.size() != 12) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=12", obs_bits.size());
    end
    for (int i = 0; i < 12 && i < obs_bits.size(); i++) begin
      exp_v = {exp_bits[11-i], ((i % 4) == 0)};
      got_v = {obs_bits[i], obs_first[i]};
      checks++;
      if (got_v !== exp_v || obs_cyc[i] != obs_cyc[0] + i) begin
        errors++;
        $display("FAIL b2b_bit_%0d got=%b cyc=%0d required=%b cyc=%0d", i,
                 got_v, obs_cyc[i], exp_v, obs_cyc[0] + i);
      end
`ifdef SEQ_TX_EXPECT_EN
      checks++;
      if (obs_dec[i] !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL b2b_dec_%0d got=%b required=%b", i, obs_dec[i], (i == 3 || i == 7));
      end
`endif
    end
  endtask

  task automatic test_full();
    logic [3:0] wv [DEPTH+1];
    logic [3:0] exp_w [DEPTH+1];
    logic [3:0] nib;
    wv[0] = 4'b1001; wv[1] = 4'b0110; wv[2] = 4'b1110; wv[3] = 4'b0001;
    wv[4] = 4'b1111;
    exp_w[0] = 4'b0101;
    for (int i = 0; i < DEPTH; i++) exp_w[i+1] = wv[i];
    clear_obs();
    push_word(4'b0101);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = wv[i];
      checks++;
      if (bus.in_ready !== (i < DEPTH)) begin
        errors++;
        $display("FAIL full_ready_%0d got=%b required=%b", i, bus.in_ready, (i < DEPTH));
      end
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    drain();
    checks++;
    if (obs_bits.size() != 4 * (DEPTH + 1)) begin
      errors++;
      $display("FAIL full_count got=%0d required=%0d", obs_bits.size(), 4 * (DEPTH + 1));
    end
    for (int f = 0; f <= DEPTH && 4 * f + 3 < obs_bits.size(); f++) begin
      nib = {obs_bits[4*f], obs_bits[4*f+1], obs_bits[4*f+2], obs_bits[4*f+3]};
      checks++;
      if (nib !== exp_w[f] || obs_cyc[4*f] != obs_cyc[0] + 4 * f) begin
        errors++;
        $display("FAIL full_word_%0d got=%b required=%b", f, nib, exp_w[f]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w [$];
    logic [3:0] w;
    logic [3:0] nib;
    clear_obs();
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      w = 4'(i * 5 + 2);
      exp_w.push_back(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_word(w);
    end
    drain();
    checks++;
    if (obs_bits.size() != 4 * exp_w.size()) begin
      errors++;
      $display("FAIL wrap_count got=%0d required=%0d", obs_bits.size(), 4 * exp_w.size());
    end
    for (int f = 0; f < exp_w.size() && 4 * f + 3 < obs_bits.size(); f++) begin
      nib = {obs_bits[4*f], obs_bits[4*f+1], obs_bits[4*f+2], obs_bits[4*f+3]};
      checks++;
      if (nib !== exp_w[f]) begin
        errors++;
        $display("FAIL wrap_word_%0d got=%b required=%b", f, nib, exp_w[f]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] nib;
    clear_obs();
    push_word(4'b1100);
    push_word(4'b0111);
    push_word(4'b1000);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out, bus.frame_first} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_pre got=%b required=111",
               {bus.out_valid, bus.out, bus.frame_first});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out, bus.out_valid, bus.frame_first, bus.in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs got=%b required=0000",
               {bus.out, bus.out_valid, bus.frame_first, bus.in_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (12) @(negedge clk);
    checks++;
    if (obs_bits.size() != 0) begin
      errors++;
      $display("FAIL midrst_silent got=%0d bits required=0", obs_bits.size());
    end
    push_word(4'b0110);
    drain();
    nib = 4'b0000;
    if (obs_bits.size() == 4) nib = {obs_bits[0], obs_bits[1], obs_bits[2], obs_bits[3]};
    checks++;
    if (obs_bits.size() != 4 || nib !== 4'b0110) begin
      errors++;
      $display("FAIL midrst_new got=%b size=%0d required=0110 size=4", nib, obs_bits.size());
    end
  endtask

  task automatic test_expect();
    logic [3:0] wv [4];
    logic       exp_dec;
    logic       exp_bit;
    wv[0] = 4'b1011; wv[1] = 4'b0011; wv[2] = 4'b1100; wv[3] = 4'b0001;
    clear_obs();
    for (int i = 0; i < 4; i++) push_word(wv[i]);
    drain();
    checks++;
    if (obs_bits.size() != 16) begin
      errors++;
      $display("FAIL expect_count got=%0d required=16", obs_bits.size());
    end
    for (int i = 0; i < 16 && i < obs_bits.size(); i++) begin
      exp_bit = wv[i/4][3-(i%4)];
      exp_dec = ((i % 4) == 3) && golden_dec(wv[i/4]);
      checks++;
      if (obs_bits[i] !== exp_bit) begin
        errors++;
        $display("FAIL expect_bit_%0d got=%b required=%b", i, obs_bits[i], exp_bit);
      end
`ifdef SEQ_TX_EXPECT_EN
      checks++;
      if (obs_dec[i] !== exp_dec) begin
        errors++;
        $display("FAIL expect_dec_%0d got=%b required=%b", i, obs_dec[i], exp_dec);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_reset_midframe();
    test_expect();
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL idle_outputs got=%0d nonzero idle cycles required=0", stray);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish before 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
